// File: rtl/axi_read_arbiter_if.sv
// Signal bundle between the two cache read requesters, the arbiter and the shared AXI read port.
// The arbiter connects through the master modport; slave is the environment's view.
interface axi_read_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              ic_arvalid, dc_arvalid;
  logic [ADDR_W-1:0] ic_araddr, dc_araddr;
  logic [7:0]        ic_arlen, dc_arlen;
  logic [2:0]        ic_arsize, dc_arsize;
  logic [1:0]        ic_arburst, dc_arburst;
  logic              ic_arready, dc_arready;
  logic              ic_rready, dc_rready;
  logic              ic_rvalid, dc_rvalid;
  logic              ic_rlast, dc_rlast;
  logic [DATA_W-1:0] ic_rdata, dc_rdata;

  logic              m_axi_arvalid;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_arready;
  logic              m_axi_rvalid, m_axi_rlast;
  logic [DATA_W-1:0] m_axi_rdata;
  logic              m_axi_rready;

  logic              instruction_cache_reading, data_cache_reading;
  logic              len_error;

  modport master (
    input  ic_arvalid, dc_arvalid, ic_araddr, dc_araddr, ic_arlen, dc_arlen,
    input  ic_arsize, dc_arsize, ic_arburst, dc_arburst, ic_rready, dc_rready,
    output ic_arready, dc_arready, ic_rvalid, dc_rvalid, ic_rlast, dc_rlast,
    output ic_rdata, dc_rdata,
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arready, m_axi_rvalid, m_axi_rlast, m_axi_rdata,
    output m_axi_rready,
    output instruction_cache_reading, data_cache_reading, len_error
  );

  modport slave (
    output ic_arvalid, dc_arvalid, ic_araddr, dc_araddr, ic_arlen, dc_arlen,
    output ic_arsize, dc_arsize, ic_arburst, dc_arburst, ic_rready, dc_rready,
    input  ic_arready, dc_arready, ic_rvalid, dc_rvalid, ic_rlast, dc_rlast,
    input  ic_rdata, dc_rdata,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arready, m_axi_rvalid, m_axi_rlast, m_axi_rdata,
    input  m_axi_rready,
    input  instruction_cache_reading, data_cache_reading, len_error
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read port between the instruction and data caches.
// One burst in flight at a time: IDLE grants, ADDR issues AR, DATA routes R beats to the owner.
module axi_read_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  axi_read_arbiter_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e            state_q, state_d;
  logic              owner_dc_q, owner_dc_d;
  logic              last_dc_q, last_dc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;

  logic              grant_ic, grant_dc;
  logic              rready_sel, beat, len_err;
  logic              in_data;
  logic [DATA_W-1:0] rdata_route;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      owner_dc_q <= 1'b0;
      last_dc_q  <= 1'b1;  // I wins the first tie
      cnt_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_dc_q <= owner_dc_d;
      last_dc_q  <= last_dc_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_dc_d = owner_dc_q;
    last_dc_d  = last_dc_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    grant_ic   = 1'b0;
    grant_dc   = 1'b0;
    rready_sel = 1'b0;
    beat       = 1'b0;
    len_err    = 1'b0;
    unique case (state_q)
      StIdle: begin
        grant_ic = bus.ic_arvalid & (~bus.dc_arvalid | last_dc_q);
        grant_dc = bus.dc_arvalid & ~grant_ic;
        if (grant_ic) begin
          addr_d     = bus.ic_araddr;
          len_d      = bus.ic_arlen;
          size_d     = bus.ic_arsize;
          burst_d    = bus.ic_arburst;
          owner_dc_d = 1'b0;
          last_dc_d  = 1'b0;
          state_d    = StAddr;
        end else if (grant_dc) begin
          addr_d     = bus.dc_araddr;
          len_d      = bus.dc_arlen;
          size_d     = bus.dc_arsize;
          burst_d    = bus.dc_arburst;
          owner_dc_d = 1'b1;
          last_dc_d  = 1'b1;
          state_d    = StAddr;
        end
      end
      StAddr: begin
        if (bus.m_axi_arready) begin
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        rready_sel = owner_dc_q ? bus.dc_rready : bus.ic_rready;
        beat       = bus.m_axi_rvalid & rready_sel;
        if (beat) begin
          cnt_d   = cnt_q + 8'd1;
          // Early rlast, or the expected final beat arriving without rlast
          len_err = bus.m_axi_rlast ? (cnt_q != len_q) : (cnt_q == len_q);
          if (bus.m_axi_rlast) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_data     = (state_q == StData);
  assign rdata_route = in_data ? bus.m_axi_rdata : '0;

  // arready is the only output combinational from inputs in IDLE, so gate it with reset
  assign bus.ic_arready = grant_ic & reset;
  assign bus.dc_arready = grant_dc & reset;

  assign bus.m_axi_arvalid = (state_q == StAddr);
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arlen   = len_q;
  assign bus.m_axi_arsize  = size_q;
  assign bus.m_axi_arburst = burst_q;
  assign bus.m_axi_rready  = rready_sel;

  assign bus.ic_rvalid = in_data & ~owner_dc_q & bus.m_axi_rvalid;
  assign bus.dc_rvalid = in_data & owner_dc_q & bus.m_axi_rvalid;
  assign bus.ic_rlast  = in_data & ~owner_dc_q & bus.m_axi_rlast;
  assign bus.dc_rlast  = in_data & owner_dc_q & bus.m_axi_rlast;
  assign bus.ic_rdata  = rdata_route;
  assign bus.dc_rdata  = rdata_route;

  assign bus.instruction_cache_reading = (state_q != StIdle) & ~owner_dc_q;
  assign bus.data_cache_reading        = (state_q != StIdle) & owner_dc_q;
  assign bus.len_error                 = len_err;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: arbitration, AR hold, beat routing, length errors, reset.
module tb_axi_read_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  axi_read_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  axi_read_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.ic_arvalid = 0; bus.dc_arvalid = 0;
    bus.ic_araddr = '0; bus.dc_araddr = '0;
    bus.ic_arlen = '0; bus.dc_arlen = '0;
    bus.ic_arsize = '0; bus.dc_arsize = '0;
    bus.ic_arburst = '0; bus.dc_arburst = '0;
    bus.ic_rready = 0; bus.dc_rready = 0;
    bus.m_axi_arready = 0; bus.m_axi_rvalid = 0; bus.m_axi_rlast = 0;
    bus.m_axi_rdata = '0;
  endtask

  // Call at a falling edge with the arbiter in IDLE; returns one cycle later in ADDR.
  task automatic request(input bit is_dc, input logic [63:0] addr, input logic [7:0] len);
    if (is_dc) begin
      bus.dc_arvalid = 1; bus.dc_araddr = addr; bus.dc_arlen = len;
      bus.dc_arsize = 3'd3; bus.dc_arburst = 2'd1;
    end else begin
      bus.ic_arvalid = 1; bus.ic_araddr = addr; bus.ic_arlen = len;
      bus.ic_arsize = 3'd3; bus.ic_arburst = 2'd1;
    end
    #1;
    chk("arready_ic", bus.ic_arready, !is_dc);
    chk("arready_dc", bus.dc_arready, is_dc);
    @(negedge clk);
    bus.ic_arvalid = 0;
    bus.dc_arvalid = 0;
  endtask

  task automatic addr_phase(input int delay, input logic [63:0] exp_addr,
                            input logic [7:0] exp_len, input bit is_dc);
    for (int i = 0; i <= delay; i++) begin
      bus.m_axi_arready = (i == delay);
      #1;
      chk("arvalid", bus.m_axi_arvalid, 1);
      chk("araddr", bus.m_axi_araddr, exp_addr);
      chk("arlen", bus.m_axi_arlen, exp_len);
      chk("arsize", bus.m_axi_arsize, 3'd3);
      chk("arburst", bus.m_axi_arburst, 2'd1);
      chk("reading_addr", is_dc ? bus.data_cache_reading : bus.instruction_cache_reading, 1);
      chk("rready_addr", bus.m_axi_rready, 0);
      @(negedge clk);
    end
    bus.m_axi_arready = 0;
    #1;
    chk("arvalid_drop", bus.m_axi_arvalid, 0);
  endtask

  // last_beat: 0-based index carrying rlast; err_mask bit n: len_error expected on beat n.
  task automatic data_phase(input bit is_dc, input int last_beat, input logic [15:0] err_mask,
                            input int exp_beats, input bit toggle, input int abort_at);
    int  beat = 0;
    bit  done = 0;
    bit  rr;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (beat == abort_at) return;
      rr = toggle ? (cyc % 2 == 0) : 1'b1;
      if (is_dc) begin bus.dc_rready = rr; bus.ic_rready = ~rr; end
      else       begin bus.ic_rready = rr; bus.dc_rready = ~rr; end
      bus.m_axi_rvalid = 1;
      bus.m_axi_rdata  = 64'hA000 + 64'(beat);
      bus.m_axi_rlast  = (beat == last_beat);
      #1;
      chk("m_rready", bus.m_axi_rready, rr);
      chk("own_rvalid", is_dc ? bus.dc_rvalid : bus.ic_rvalid, 1);
      chk("oth_rvalid", is_dc ? bus.ic_rvalid : bus.dc_rvalid, 0);
      chk("own_rlast", is_dc ? bus.dc_rlast : bus.ic_rlast, beat == last_beat);
      chk("oth_rlast", is_dc ? bus.ic_rlast : bus.dc_rlast, 0);
      chk("rdata", is_dc ? bus.dc_rdata : bus.ic_rdata, 64'hA000 + 64'(beat));
      chk("len_error", bus.len_error, rr && err_mask[beat]);
      chk("own_reading", is_dc ? bus.data_cache_reading : bus.instruction_cache_reading, 1);
      chk("oth_reading", is_dc ? bus.instruction_cache_reading : bus.data_cache_reading, 0);
      if (rr) begin
        if (beat == last_beat) done = 1;
        beat++;
      end
      @(negedge clk);
    end
    chk("data_done", done, 1);
    chk("beats", beat, exp_beats);
    // Back in IDLE: nothing may be routed even with R traffic present
    bus.m_axi_rlast = 0;
    bus.ic_rready = 1; bus.dc_rready = 1;
    #1;
    chk("idle_rready", bus.m_axi_rready, 0);
    chk("idle_rvalid", is_dc ? bus.dc_rvalid : bus.ic_rvalid, 0);
    chk("idle_reading", is_dc ? bus.data_cache_reading : bus.instruction_cache_reading, 0);
    chk("idle_len_error", bus.len_error, 0);
    bus.m_axi_rvalid = 0;
    bus.ic_rready = 0; bus.dc_rready = 0;
  endtask

  initial begin
    clear_inputs();
    bus.ic_arvalid = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_arready", bus.ic_arready, 0);
    chk("rst_arvalid", bus.m_axi_arvalid, 0);
    chk("rst_araddr", bus.m_axi_araddr, 0);
    chk("rst_rready", bus.m_axi_rready, 0);
    chk("rst_reading", bus.instruction_cache_reading | bus.data_cache_reading, 0);
    bus.ic_arvalid = 0;
    reset = 1;

    // Tie after reset: I wins, D is held and wins the next IDLE cycle
    @(negedge clk);
    bus.ic_arvalid = 1; bus.ic_araddr = 64'h1000; bus.ic_arlen = 8'd7;
    bus.ic_arsize = 3'd3; bus.ic_arburst = 2'd1;
    bus.dc_arvalid = 1; bus.dc_araddr = 64'h2000; bus.dc_arlen = 8'd7;
    bus.dc_arsize = 3'd3; bus.dc_arburst = 2'd1;
    #1;
    chk("tie1_ic", bus.ic_arready, 1);
    chk("tie1_dc", bus.dc_arready, 0);
    @(negedge clk);
    bus.ic_arvalid = 0;
    #1;
    chk("held_dc", bus.dc_arready, 0);
    addr_phase(0, 64'h1000, 8'd7, 0);
    data_phase(0, 7, 16'h0000, 8, 0, -1);
    chk("dc_grant", bus.dc_arready, 1);
    chk("dc_grant_ic", bus.ic_arready, 0);
    @(negedge clk);
    bus.dc_arvalid = 0;
    addr_phase(0, 64'h2000, 8'd7, 1);
    data_phase(1, 7, 16'h0000, 8, 0, -1);

    // D alone, AR ready delayed by 4 cycles
    @(negedge clk);
    request(1, 64'h3000, 8'd3);
    addr_phase(4, 64'h3000, 8'd3, 1);
    data_phase(1, 3, 16'h0000, 4, 0, -1);

    // I with rready toggling
    @(negedge clk);
    request(0, 64'h4000, 8'd7);
    addr_phase(1, 64'h4000, 8'd7, 0);
    data_phase(0, 7, 16'h0000, 8, 1, -1);

    // arlen=3 but rlast on beat 6: error at count==len and again at late rlast
    @(negedge clk);
    request(1, 64'h5000, 8'd3);
    addr_phase(0, 64'h5000, 8'd3, 1);
    data_phase(1, 5, 16'h0028, 6, 0, -1);

    // arlen=7, early rlast on beat 5
    @(negedge clk);
    request(0, 64'h6000, 8'd7);
    addr_phase(0, 64'h6000, 8'd7, 0);
    data_phase(0, 4, 16'h0010, 5, 0, -1);

    // Last grant was I, so D wins this tie
    @(negedge clk);
    bus.ic_arvalid = 1; bus.ic_araddr = 64'h1111; bus.ic_arlen = 8'd0;
    bus.dc_arvalid = 1; bus.dc_araddr = 64'h2222; bus.dc_arlen = 8'd0;
    #1;
    chk("tie2_dc", bus.dc_arready, 1);
    chk("tie2_ic", bus.ic_arready, 0);
    @(negedge clk);
    bus.ic_arvalid = 0; bus.dc_arvalid = 0;
    addr_phase(0, 64'h2222, 8'd0, 1);
    data_phase(1, 0, 16'h0000, 1, 0, -1);

    // Reset during beat 3 of an 8-beat burst
    @(negedge clk);
    request(0, 64'h7000, 8'd7);
    addr_phase(0, 64'h7000, 8'd7, 0);
    data_phase(0, 7, 16'h0000, 8, 0, 2);
    bus.ic_rready = 1;
    bus.ic_arvalid = 1;
    bus.m_axi_rvalid = 1;
    bus.m_axi_rdata = 64'hA002;
    reset = 0;
    #1;
    chk("mid_rst_rready", bus.m_axi_rready, 0);
    chk("mid_rst_rvalid", bus.ic_rvalid, 0);
    chk("mid_rst_rdata", bus.ic_rdata, 0);
    chk("mid_rst_reading", bus.instruction_cache_reading, 0);
    chk("mid_rst_araddr", bus.m_axi_araddr, 0);
    chk("mid_rst_arlen", bus.m_axi_arlen, 0);
    chk("mid_rst_arready", bus.ic_arready, 0);
    @(negedge clk);
    bus.ic_arvalid = 0;
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("post_rst_arvalid", bus.m_axi_arvalid, 0);
      chk("post_rst_rvalid", bus.ic_rvalid, 0);
      chk("post_rst_reading", bus.instruction_cache_reading, 0);
      @(negedge clk);
    end
    bus.m_axi_rvalid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
